reg_dump_ctrl: RTL and testbench
================================

Name: reg_dump_ctrl

Overview:
- Initiator side of the CPU debug register-read port (reg_sel out, reg_data in) on sccomp.
- On a start pulse, steps reg_sel through a register range and waits a settle time per index.
- Captures reg_data for each index and presents each (index, value) pair on a valid/ready output stream.
- The stream feeds display and UART dump logic; this block replaces manual reg_sel driving in benches and on the board.

Parameters:
- SEL_W, 5, width of reg_sel and out_idx.
- DATA_W, 32, width of reg_data and out_data.
- FIRST_REG, 0, first register index dumped.
- LAST_REG, 31, last register index dumped. Must be >= FIRST_REG and < 2**SEL_W.
- SETTLE, 2, cycles reg_sel is held before sampling. Must be >= 1.

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE
- abort  in  1  synchronous cancel of a dump in progress
- reg_sel  out  SEL_W  register index driven to the CPU debug port
- reg_data  in  DATA_W  register value returned by the CPU (combinational from reg_sel)
- out_valid  out  1  out_idx/out_data hold a captured pair
- out_ready  in  1  consumer accepts the pair when out_valid=1
- out_idx  out  SEL_W  index of the captured register
- out_data  out  DATA_W  captured register value
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last pair is accepted

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE; reg_sel=0, out_valid=0, out_idx=0, out_data=0, busy=0, done=0, settle counter=0.
- States: IDLE, WAIT, EMIT, DONE.
- IDLE:
  - start=1 at edge T -> WAIT at T+1.
  - Same edge: reg_sel<=FIRST_REG, counter<=SETTLE-1.
  - reg_sel otherwise holds its last value in IDLE.
- WAIT:
  - Counter>0: decrement.
  - Counter==0: out_data<=reg_data, out_idx<=reg_sel, out_valid<=1, go to EMIT.
  - Result: WAIT lasts exactly SETTLE cycles; first out_valid rises at T+1+SETTLE.
- EMIT:
  - out_valid, out_idx and out_data stay stable until out_valid&out_ready.
  - Handshake with reg_sel<LAST_REG: out_valid<=0, reg_sel<=reg_sel+1, counter<=SETTLE-1, go to WAIT.
  - Handshake with reg_sel==LAST_REG: out_valid<=0, go to DONE.
  - out_ready high continuously: one pair every SETTLE+1 cycles.
- DONE: done=1 for exactly this one cycle, then IDLE. busy is still 1 here.
- abort=1 in WAIT, EMIT or DONE: next state IDLE, out_valid<=0, no done pulse; reg_sel holds. abort overrides a same-cycle handshake.
- start while busy: ignored.
- start and abort together in IDLE: abort wins, stay in IDLE.
- No wrap-around: reg_sel never increments past LAST_REG.
- FIRST_REG==LAST_REG: exactly one pair, then done.
- out_valid never drops without a handshake, except on abort or reset.
- rstn low mid-dump: outputs take reset values immediately. After release, stay IDLE until the next start.

Decomposition:
- Shared package (cpu_dbg_pkg):
  - state enum {IDLE, WAIT, EMIT, DONE}.
  - Constants DBG_SEL_W=5 and DBG_DATA_W=32, shared with sccomp's debug port.
- Single module. The settle counter is a few lines inline, so no sub-module.

Test Plan:
- Reset: rstn=0 mid-EMIT -> same-cycle out_valid=0, busy=0, reg_sel=0; no done after release.
- Full dump, out_ready=1, SETTLE=2, CPU model returns 0x1000+sel:
  - 32 pairs (0,0x1000)..(31,0x101F), one every 3 cycles.
  - First out_valid at start+3.
  - done pulse one cycle after pair 31; busy low the following cycle.
- Backpressure: out_ready=0 for 10 cycles on pair 7 -> out_idx=7, out_data=0x1007 held stable; reg_sel stays 7; resumes correctly when out_ready=1.
- Abort: abort in WAIT at index 12 -> IDLE next cycle, out_valid=0, no done; a new start dumps from index 0 again.
- Ignored start: start pulsed while busy at index 5 -> no restart; the sequence completes 0..31 exactly once.
- Single register, FIRST_REG=LAST_REG=7, reg_data=0xDEADBEEF -> exactly one pair (7, 0xDEADBEEF), then done.

Source files
------------

// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the CPU debug register-read port.
// Contents:
//   DBG_SEL_W, DBG_DATA_W - debug port widths, matching sccomp's debug port
//   dump_state_e          - reg_dump_ctrl sequencing states
package cpu_dbg_pkg;

    localparam int unsigned DBG_SEL_W  = 5;
    localparam int unsigned DBG_DATA_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StEmit,
        StDone
    } dump_state_e;

endpackage

// File: rtl/reg_dump_ctrl.sv
// Register dump controller: on start, walks reg_sel from FIRST_REG to LAST_REG,
// holds each index for SETTLE cycles, captures reg_data and offers the
// (index, value) pair on a valid/ready stream.
// Ports:
//   clk, rstn            - clock, asynchronous active-low reset
//   start, abort         - begin a dump (IDLE only) / cancel a dump in progress
//   reg_sel, reg_data    - CPU debug read port (data is combinational from sel)
//   out_valid, out_ready - output stream handshake
//   out_idx, out_data    - captured register index and value
//   busy, done           - activity flag, one-cycle completion pulse
module reg_dump_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int unsigned SEL_W     = DBG_SEL_W,
    parameter int unsigned DATA_W    = DBG_DATA_W,
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31,
    parameter int unsigned SETTLE    = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    output logic [SEL_W-1:0]  reg_sel,
    input  logic [DATA_W-1:0] reg_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SEL_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    // Counter only ever holds SETTLE-1 down to 0.
    localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    dump_state_e       state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              valid_q, valid_d;
    logic [SEL_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        data_d  = data_q;

        if (abort) begin
            // Abort beats start in IDLE and a same-cycle handshake elsewhere.
            state_d = StIdle;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StWait;
                        sel_d   = SEL_W'(FIRST_REG);
                        cnt_d   = CntW'(SETTLE - 1);
                    end
                end
                StWait: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CntW'(1);
                    end else begin
                        data_d  = reg_data;
                        idx_d   = sel_q;
                        valid_d = 1'b1;
                        state_d = StEmit;
                    end
                end
                StEmit: begin
                    if (out_ready) begin
                        valid_d = 1'b0;
                        if (sel_q == SEL_W'(LAST_REG)) begin
                            state_d = StDone;
                        end else begin
                            sel_d   = sel_q + SEL_W'(1);
                            cnt_d   = CntW'(SETTLE - 1);
                            state_d = StWait;
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign reg_sel   = sel_q;
    assign out_valid = valid_q;
    assign out_idx   = idx_q;
    assign out_data  = data_q;
    assign busy      = (state_q != StIdle);
    // An abort arriving in DONE suppresses the pulse.
    assign done      = (state_q == StDone) && !abort;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
module tb_reg_dump_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0, abort = 1'b0, ready = 1'b1;
    logic [4:0]  reg_sel, out_idx;
    logic [31:0] reg_data, out_data;
    logic        out_valid, busy, done;

    logic        start1 = 1'b0;
    logic [4:0]  reg_sel1, out_idx1;
    logic [31:0] out_data1;
    logic        out_valid1, busy1, done1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // CPU model: register n reads as 0x1000 + n.
    assign reg_data = 32'h1000 + {27'd0, reg_sel};

    reg_dump_ctrl #(
        .SEL_W(5), .DATA_W(32), .FIRST_REG(0), .LAST_REG(31), .SETTLE(2)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .reg_sel(reg_sel), .reg_data(reg_data),
        .out_valid(out_valid), .out_ready(ready),
        .out_idx(out_idx), .out_data(out_data),
        .busy(busy), .done(done)
    );

    reg_dump_ctrl #(
        .SEL_W(5), .DATA_W(32), .FIRST_REG(7), .LAST_REG(7), .SETTLE(3)
    ) dut1 (
        .clk(clk), .rstn(rstn), .start(start1), .abort(1'b0),
        .reg_sel(reg_sel1), .reg_data(32'hDEADBEEF),
        .out_valid(out_valid1), .out_ready(1'b1),
        .out_idx(out_idx1), .out_data(out_data1),
        .busy(busy1), .done(done1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       start;
        logic       abort;
        logic       ready;
        logic       exp_valid;
        logic [4:0] exp_sel;
        logic [4:0] exp_idx;
        logic       exp_busy;
    } vec_t;

    // Full dump against a model: expected pairs are simply 0..31 in order.
    task automatic run_dump(input bit rnd);
        int          exp_n = 0;
        int          ticks = 0;
        int          last_acc = 0;
        int          stall = 0;
        bit          seen_valid = 1'b0;
        bit          fin = 1'b0;
        logic        pv, pr;
        logic [4:0]  pi;
        logic [31:0] pd;
        start = 1'b1;
        ready = 1'b1;
        tick();
        ticks = 1;
        start = 1'b0;
        while (!fin && ticks < 3000) begin
            if (rnd) begin
                ready = 1'($urandom_range(0, 1));
                start = ($urandom_range(0, 7) == 0);
            end else begin
                start = 1'b0;
                if (out_valid && out_idx == 5'd7 && stall < 10) begin
                    ready = 1'b0;
                    stall++;
                end else begin
                    ready = 1'b1;
                end
            end
            pv = out_valid;
            pr = ready;
            pi = out_idx;
            pd = out_data;
            tick();
            ticks++;
            if (!seen_valid && out_valid) begin
                seen_valid = 1'b1;
                if (!rnd) check("first_valid_latency", ticks, 3);
            end
            if (pv && pr) begin
                check("pair_idx", pi, exp_n);
                check("pair_data", pd, 32'h1000 + exp_n);
                if (!rnd && exp_n > 0)
                    check("pair_interval", ticks - last_acc, (exp_n == 7) ? 13 : 3);
                last_acc = ticks;
                check("valid_drop_after_accept", out_valid, 0);
                if (exp_n == 31) begin
                    check("done_after_last", done, 1);
                    fin = 1'b1;
                end
                exp_n++;
            end else if (pv) begin
                check("hold_valid", out_valid, 1);
                check("hold_idx", out_idx, pi);
                check("hold_data", out_data, pd);
                if (!rnd && pi == 5'd7) check("bp_sel_held", reg_sel, 7);
            end else if (done) begin
                check("premature_done", done, 0);
            end
        end
        check("dump_completed", fin, 1);
        start = 1'b0;
        ready = 1'b1;
        tick();
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
    endtask

    vec_t tbl[11];
    int   n;
    int   extra;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 5'd0, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 5'd0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 5'd1, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 5'd0, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 5'd0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 5'd0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 5'd0, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sel", reg_sel, 0);
        check("rst_idx", out_idx, 0);
        check("rst_data", out_data, 0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // Cycle-accurate vectors: start, settle, backpressure, handshake, abort
        for (int i = 0; i < 11; i++) begin
            start = tbl[i].start;
            abort = tbl[i].abort;
            ready = tbl[i].ready;
            tick();
            check($sformatf("vec%0d_valid", i), out_valid, tbl[i].exp_valid);
            check($sformatf("vec%0d_sel", i), reg_sel, tbl[i].exp_sel);
            check($sformatf("vec%0d_busy", i), busy, tbl[i].exp_busy);
            check($sformatf("vec%0d_done", i), done, 0);
            if (tbl[i].exp_valid) begin
                check($sformatf("vec%0d_idx", i), out_idx, tbl[i].exp_idx);
                check($sformatf("vec%0d_data", i), out_data, 32'h1000 + tbl[i].exp_idx);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        ready = 1'b1;

        // Full dump with backpressure on pair 7, then random ready/start
        run_dump(1'b0);
        run_dump(1'b1);
        run_dump(1'b1);

        // Abort in WAIT at index 12, then a fresh dump from index 0
        start = 1'b1;
        ready = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(busy && !out_valid && reg_sel == 5'd12) && n < 500) begin
            tick();
            n++;
        end
        check("abort_reach_12", reg_sel, 12);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", out_valid, 0);
        check("abort_done", done, 0);
        check("abort_sel_held", reg_sel, 12);
        tick();
        check("abort_no_done_later", done, 0);
        run_dump(1'b0);

        // Reset asserted mid-EMIT
        start = 1'b1;
        ready = 1'b0;
        tick();
        start = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("pre_reset_valid", out_valid, 1);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_sel", reg_sel, 0);
        @(negedge clk);
        rstn = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_idle", busy, 0);
            check("post_rst_no_done", done, 0);
        end

        // Single-register instance: FIRST_REG == LAST_REG == 7, SETTLE 3
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 1;
        while (!out_valid1 && n < 20) begin
            tick();
            n++;
        end
        check("single_latency", n, 4);
        check("single_idx", out_idx1, 7);
        check("single_data", out_data1, 32'hDEADBEEF);
        check("single_sel", reg_sel1, 7);
        tick();
        check("single_done", done1, 1);
        check("single_valid_drop", out_valid1, 0);
        tick();
        check("single_idle", busy1, 0);
        check("single_done_pulse", done1, 0);
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid1 || done1) extra++;
        end
        check("single_no_more_pairs", extra, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
